// File: rtl/crossbar_pkg.sv
// ---------------------------------------------------------------------------
// crossbar_pkg
// Shared constants and types for the 4x4 crossbar slave-side arbitration.
//   QTY_OF_MASTERS : number of masters that can request a slave port
//   QTY_OF_SLAVES  : number of slave ports (one arbiter instance each)
//   arb_state_t    : per-slave arbiter state encoding
// ---------------------------------------------------------------------------
package crossbar_pkg;

    localparam int QTY_OF_MASTERS = 4;
    localparam int QTY_OF_SLAVES  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

endpackage : crossbar_pkg

// File: rtl/slave_rr_arbiter_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin selector: returns the first set bit of req found
// when scanning upward from ptr and wrapping back to bit 0.
//   req   in  N        request vector
//   ptr   in  log2(N)  highest-priority position for this scan
//   found out 1        at least one request bit is set
//   idx   out log2(N)  index of the selected request
// The wrap is handled by scanning a doubled copy of req with every position
// below ptr masked off; the lowest surviving bit, folded modulo N, is the
// winner. Any set bit is guaranteed to survive in the upper copy, so the
// scan never misses a request.
// ---------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [2*N-1:0] req_dbl_s;
    logic [2*N-1:0] mask_s;
    logic [2*N-1:0] hit_s;

    // Build the masked double-width vector and pick its lowest set bit.
    always_comb begin
        req_dbl_s = {req, req};
        for (int i = 0; i < 2 * N; i++) begin
            mask_s[i] = (i >= int'(ptr));
        end
        hit_s = req_dbl_s & mask_s;
        found = 1'b0;
        idx   = {IW{1'b0}};
        // Scan from the top down so the lowest hit is the last one written.
        for (int i = 2 * N - 1; i >= 0; i--) begin
            found = found | hit_s[i];
            idx   = hit_s[i] ? IW'(i % N) : idx;
        end
    end

endmodule : rr_priority_picker

// File: rtl/slave_rr_arbiter.sv
// ---------------------------------------------------------------------------
// slave_rr_arbiter
// Per-slave round-robin arbiter of the 4x4 crossbar. Grants the slave to one
// master at a time, holds the grant until the slave acknowledges, opens a
// one-cycle read-response routing window after acknowledged reads, and
// force-releases a grant that the slave never acknowledges.
//   clk          in   1        clock, all logic on posedge
//   rst          in   1        synchronous active-high reset
//   req          in   M        request bit m from master m's listener
//   cmd_is_read  in   M        bit m set = master m's command is a read
//   slave_ack    in   1        slave accepts the granted transaction
//   grant        out  M        one-hot grant (crossbar mux selects), 0 when idle
//   grant_idx    out  log2(M)  index of the current / most recent grantee
//   resp_valid   out  1        read-data routing window to master resp_idx
//   resp_idx     out  log2(M)  master receiving read data
//   timeout      out  1        one-cycle pulse on watchdog release
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module slave_rr_arbiter #(
    parameter int QTY_OF_MASTERS = crossbar_pkg::QTY_OF_MASTERS,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [QTY_OF_MASTERS-1:0]         req,
    input  logic [QTY_OF_MASTERS-1:0]         cmd_is_read,
    input  logic                              slave_ack,
    output logic [QTY_OF_MASTERS-1:0]         grant,
    output logic [$clog2(QTY_OF_MASTERS)-1:0] grant_idx,
    output logic                              resp_valid,
    output logic [$clog2(QTY_OF_MASTERS)-1:0] resp_idx,
    output logic                              timeout
);

    import crossbar_pkg::*;

    localparam int IW  = $clog2(QTY_OF_MASTERS);
    localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [WDW-1:0] WD_MAX  = {WDW{1'b1}};

    // Index-to-one-hot conversion for the crossbar mux selects.
    function automatic logic [QTY_OF_MASTERS-1:0] idx_to_onehot(input logic [IW-1:0] i);
        logic [QTY_OF_MASTERS-1:0] one_v;
        one_v = {{(QTY_OF_MASTERS - 1){1'b0}}, 1'b1};
        return one_v << i;
    endfunction

    // Registered state
    arb_state_t                state_r;
    logic [IW-1:0]             rr_ptr_r;
    logic [WDW-1:0]            wd_cnt_r;
    logic                      is_rd_r;
    logic [QTY_OF_MASTERS-1:0] grant_r;
    logic [IW-1:0]             grant_idx_r;
    logic                      resp_valid_r;
    logic [IW-1:0]             resp_idx_r;
    logic                      timeout_r;

    // Next-state values
    arb_state_t                state_s;
    logic [IW-1:0]             rr_ptr_s;
    logic [WDW-1:0]            wd_cnt_s;
    logic                      is_rd_s;
    logic [QTY_OF_MASTERS-1:0] grant_s;
    logic [IW-1:0]             grant_idx_s;
    logic                      resp_valid_s;
    logic [IW-1:0]             resp_idx_s;
    logic                      timeout_s;

    // Picker results
    logic                      pick_found_s;
    logic [IW-1:0]             pick_idx_s;

    rr_priority_picker #(
        .N  (QTY_OF_MASTERS),
        .IW (IW)
    ) u_picker (
        .req   (req),
        .ptr   (rr_ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Arbitration FSM: next state, pointer, watchdog and output values.
    always_comb begin
        state_s      = state_r;
        rr_ptr_s     = rr_ptr_r;
        wd_cnt_s     = wd_cnt_r;
        is_rd_s      = is_rd_r;
        grant_s      = grant_r;
        grant_idx_s  = grant_idx_r;
        resp_valid_s = 1'b0;
        resp_idx_s   = resp_idx_r;
        timeout_s    = 1'b0;

        case (state_r)
            ARB_IDLE: begin
                if (pick_found_s) begin
                    state_s     = ARB_BUSY;
                    grant_s     = idx_to_onehot(pick_idx_s);
                    grant_idx_s = pick_idx_s;
                    is_rd_s     = cmd_is_read[pick_idx_s];
                    wd_cnt_s    = {WDW{1'b0}};
                end else begin
                    grant_s     = {QTY_OF_MASTERS{1'b0}};
                end
            end

            ARB_BUSY: begin
                if (slave_ack) begin
                    // Served master drops to lowest priority.
                    grant_s  = {QTY_OF_MASTERS{1'b0}};
                    rr_ptr_s = grant_idx_r + IW'(1'b1);
                    if (is_rd_r) begin
                        state_s      = ARB_RESP;
                        resp_valid_s = 1'b1;
                        resp_idx_s   = grant_idx_r;
                    end else begin
                        state_s      = ARB_IDLE;
                    end
                end else if (!req[grant_idx_r]) begin
                    // Withdrawn request was never served, so fairness is untouched.
                    state_s = ARB_IDLE;
                    grant_s = {QTY_OF_MASTERS{1'b0}};
                end else if (wd_cnt_r == WD_LAST) begin
                    state_s   = ARB_IDLE;
                    grant_s   = {QTY_OF_MASTERS{1'b0}};
                    timeout_s = 1'b1;
                    rr_ptr_s  = grant_idx_r + IW'(1'b1);
                end else begin
                    // Saturating count keeps a stuck counter from wrapping back.
                    wd_cnt_s = (wd_cnt_r == WD_MAX) ? wd_cnt_r : wd_cnt_r + WDW'(1'b1);
                end
            end

            ARB_RESP: begin
                state_s = ARB_IDLE;
                grant_s = {QTY_OF_MASTERS{1'b0}};
            end

            default: begin
                state_s = ARB_IDLE;
                grant_s = {QTY_OF_MASTERS{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ARB_IDLE;
            rr_ptr_r     <= {IW{1'b0}};
            wd_cnt_r     <= {WDW{1'b0}};
            is_rd_r      <= 1'b0;
            grant_r      <= {QTY_OF_MASTERS{1'b0}};
            grant_idx_r  <= {IW{1'b0}};
            resp_valid_r <= 1'b0;
            resp_idx_r   <= {IW{1'b0}};
            timeout_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            rr_ptr_r     <= rr_ptr_s;
            wd_cnt_r     <= wd_cnt_s;
            is_rd_r      <= is_rd_s;
            grant_r      <= grant_s;
            grant_idx_r  <= grant_idx_s;
            resp_valid_r <= resp_valid_s;
            resp_idx_r   <= resp_idx_s;
            timeout_r    <= timeout_s;
        end
    end

    assign grant      = grant_r;
    assign grant_idx  = grant_idx_r;
    assign resp_valid = resp_valid_r;
    assign resp_idx   = resp_idx_r;
    assign timeout    = timeout_r;

endmodule : slave_rr_arbiter

// File: tb/tb_slave_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_slave_rr_arbiter
// Directed vectors with hand-computed expected outputs. Each stimulus step
// drives inputs at the falling edge and queues the outputs expected after the
// next rising edge; a separate monitor pops and compares 1 time unit after
// every rising edge.
// ---------------------------------------------------------------------------
module tb_slave_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] cmd_is_read = 4'b0000;
    logic       slave_ack = 1'b0;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       resp_valid;
    logic [1:0] resp_idx;
    logic       timeout;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] idx;
        logic       rv;
        logic [1:0] ridx;
        logic       chk_ridx;
        logic       to;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    vectors_applied = 0;
    int    miscompares = 0;

    slave_rr_arbiter #(
        .QTY_OF_MASTERS (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .cmd_is_read (cmd_is_read),
        .slave_ack   (slave_ack),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .resp_valid  (resp_valid),
        .resp_idx    (resp_idx),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] rd,
                        input logic ak, input logic [3:0] eg, input logic [1:0] ei,
                        input logic erv, input logic [1:0] eri, input logic eto,
                        input string nm);
        exp_t e;
        @(negedge clk);
        rst         = r;
        req         = rq;
        cmd_is_read = rd;
        slave_ack   = ak;
        e.grant    = eg;
        e.idx      = ei;
        e.rv       = erv;
        e.ridx     = eri;
        e.chk_ridx = erv | r;
        e.to       = eto;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare DUT outputs against the queued expectation.
    initial begin
        exp_t  e;
        string nm;
        logic  bad;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                vectors_applied++;
                bad = (grant !== e.grant) || (grant_idx !== e.idx) ||
                      (resp_valid !== e.rv) || (timeout !== e.to) ||
                      (e.chk_ridx && (resp_idx !== e.ridx));
                if (bad) begin
                    miscompares++;
                    $display("FAIL %s: got grant=%b idx=%0d resp_valid=%b resp_idx=%0d timeout=%b; expected grant=%b idx=%0d resp_valid=%b resp_idx=%0d timeout=%b",
                             nm, grant, grant_idx, resp_valid, resp_idx, timeout,
                             e.grant, e.idx, e.rv, e.ridx, e.to);
                end
            end
        end
    end

    // Global time limit so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached with %0d expectations pending, expected 0",
                 exp_q.size());
        $fatal(1, "time limit");
    end

    initial begin
        // Reset
        step(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0, 1'b0, "reset0");
        step(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0, 1'b0, "reset1");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0, 1'b0, "idle_noreq");

        // Single write by m0, ack in the 3rd BUSY cycle; m3 request ignored while busy
        step(1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 2'd0, 1'b0, "wr_grant");
        step(1'b0, 4'b1001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 2'd0, 1'b0, "wr_busy2_hold");
        step(1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 2'd0, 1'b0, "wr_busy3");
        step(1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0, 1'b0, "wr_ack_release");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0, 1'b0, "wr_idle");

        // Single read by m2 (rr_ptr=1); is_rd latched at grant; requests ignored in RESP
        step(1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, 2'd0, 1'b0, "rd_grant");
        step(1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b1, 2'd2, 1'b0, "rd_resp_window");
        step(1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 2'd0, 1'b0, "rd_resp_end");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 2'd0, 1'b0, "rd_idle");

        // Wrap and skip from rr_ptr=3
        step(1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 2'd0, 1'b0, "wrap_grant_m0");
        step(1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0, 1'b0, "wrap_ack_m0");
        step(1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b0, 2'd0, 1'b0, "skip_grant_m2");
        step(1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 2'd0, 1'b0, "skip_ack_m2");

        // Watchdog: m1 never acknowledged, grant held 16 cycles then timeout pulse
        step(1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, 2'd0, 1'b0, "to_grant");
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, 2'd0, 1'b0, "to_hold");
        end
        step(1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 2'd0, 1'b1, "to_release");
        step(1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, 2'd0, 1'b0, "to_regrant_m1");
        step(1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 2'd0, 1'b0, "to_regrant_ack");

        // Withdraw by m3 leaves rr_ptr at 2, so m3 still beats m0 afterwards
        step(1'b0, 4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b0, 2'd0, 1'b0, "wd_grant_m3");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 2'd0, 1'b0, "wd_withdraw");
        step(1'b0, 4'b1001, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0, 2'd0, 1'b0, "wd_ptr_kept");

        // Reset during a BUSY read with ack present: no response window, no pulse
        step(1'b1, 4'b1001, 4'b1000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0, 1'b0, "rst_busy");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0, 1'b0, "rst_after");

        // Fairness from rr_ptr=0 with all masters requesting, immediate acks
        step(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 2'd0, 1'b0, "fair_g0");
        step(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0, 1'b0, "fair_a0");
        step(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, 2'd0, 1'b0, "fair_g1");
        step(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 2'd0, 1'b0, "fair_a1");
        step(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b0, 2'd0, 1'b0, "fair_g2");
        step(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 2'd0, 1'b0, "fair_a2");
        step(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b0, 2'd0, 1'b0, "fair_g3");
        step(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 2'd0, 1'b0, "fair_a3");
        step(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 2'd0, 1'b0, "fair_g0_again");
        step(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0, 1'b0, "fair_a0_again");

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() > 0) begin
                @(posedge clk);
                #2;
            end
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule : tb_slave_rr_arbiter
